multiport_banked_ram: RTL and testbench
=======================================

MULTIPORT_BANKED_RAM -- requirements
Module: multiport_banked_ram

Interface
REQ-001 SHALL have parameter mem_size, default 4096, total data words; SHALL be a multiple of bank_count.
REQ-002 SHALL have parameter mem_width, default 12, data word width.
REQ-003 SHALL have parameter addr_width, default 12, per-port address width.
REQ-004 SHALL have parameter port_count, default 2, number of core ports (1..8).
REQ-005 SHALL have parameter bank_count, default 4, number of single-access banks (power of 2, 1..16).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req  input  port_count  per-port access request.
REQ-009 mem_write  input  port_count  per-port access type: 1 = write, 0 = read; meaningful only with req.
REQ-010 address  input  addr_width*port_count  flattened addresses; port j occupies bits [(j+1)*addr_width-1 : j*addr_width].
REQ-011 datain  input  mem_width*port_count  flattened write data, same packing as address.
REQ-012 grant  output  port_count  combinational per-port grant in the request cycle.
REQ-013 dataout  output  mem_width*port_count  registered flattened read data, same packing.
REQ-014 valid  output  port_count  registered one-cycle pulse marking new read data on the port.

Function
REQ-015 Bank select SHALL be address[log2(bank_count)-1:0]; row SHALL be address >> log2(bank_count).
REQ-016 Each bank SHALL perform at most one access per cycle.
REQ-017 Ports requesting different banks SHALL all be granted in the same cycle.
REQ-018 When several ports request one bank, exactly one SHALL be granted, chosen round-robin from that bank's pointer.
REQ-019 Arbitration SHALL check ports in order ptr, ptr+1, ... modulo port_count.
REQ-020 After a grant in a bank, that bank's pointer SHALL become (winner+1) mod port_count; with no grant, the pointer SHALL hold.
REQ-021 An ungranted requester SHALL keep req, mem_write, address and datain stable until granted; the block SHALL not queue requests.
REQ-022 A granted write SHALL commit datain to the addressed word at the end of the grant cycle; valid SHALL stay low for writes.
REQ-023 For a granted read in cycle n, dataout for that port SHALL show the word in cycle n+1 with valid=1 in n+1 only.
REQ-024 dataout SHALL hold its last value when valid is low.
REQ-025 A read of a word written in an earlier cycle SHALL return the new value, with no extra latency.
REQ-026 Any address >= mem_size SHALL still be arbitrated and granted; writes SHALL be dropped, and reads SHALL return 0 with valid=1.
REQ-027 grant SHALL be 0 for any port with req=0; grant SHALL never be asserted to two ports on the same bank.
REQ-028 Read data width SHALL equal mem_width, with no truncation or extension.

Reset
REQ-029 While reset=1, grant SHALL be 0 and no write SHALL commit.
REQ-030 On the reset edge, all bank pointers SHALL be set to 0, and all dataout and valid bits SHALL be cleared to 0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 A read granted in the cycle before reset asserts SHALL NOT produce valid.

Verification (port_count=2, bank_count=4, mem_width=12, mem_size=4096 unless stated)
REQ-033 Reset held 2 cycles -> dataout=0, valid=2'b00, grant=2'b00, all pointers 0.
REQ-034 Port0 writes 12'h0A5 to 12'h010 in cycle n, then reads 12'h010 in cycle n+1 -> grant[0]=1 in both cycles; dataout0=12'h0A5 and valid=2'b01 in n+2 only.
REQ-035 Bank conflict after reset: port0 reads 12'h004 and port1 reads 12'h008, both held until granted.
  - cycle n: grant=2'b01.
  - cycle n+1: grant=2'b10.
  - Each port sees a valid pulse one cycle after its grant.
  - Repeating the conflict in n+2 -> grant=2'b01 (pointer alternates).
REQ-036 No conflict: port0 writes 12'h3C3 to 12'h001 and port1 writes 12'h5A5 to 12'h002 in the same cycle -> grant=2'b11; later reads return 12'h3C3 and 12'h5A5.
REQ-037 With mem_size=2048, write 12'hFFF to 12'h900 then read 12'h900 -> both granted; read gives dataout=0 with valid=1; word 12'h100 is unchanged.
REQ-038 Reset asserted in the cycle after a granted read -> valid=0 and dataout=0 after the reset edge; contents written earlier are still readable after reset.

Source files
------------

// File: rtl/multiport_banked_ram.sv
// multiport_banked_ram
//   Shared RAM built from bank_count single-access banks serving port_count
//   core ports. Low address bits pick the bank, the remaining bits pick the
//   row. Each bank has its own round-robin arbiter, so ports hitting
//   different banks proceed together. Contending ports are not queued: a
//   losing port keeps its request stable until it is granted.
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   req        per-port access request
//   mem_write  per-port access type (1 write, 0 read)
//   address    flattened per-port addresses, port j at [(j+1)*addr_width-1 -: addr_width]
//   datain     flattened per-port write data, same packing
//   grant      combinational per-port grant in the request cycle
//   dataout    registered flattened read data, held between reads
//   valid      one-cycle pulse marking new read data on a port
module multiport_banked_ram #(
  parameter int mem_size   = 4096,
  parameter int mem_width  = 12,
  parameter int addr_width = 12,
  parameter int port_count = 2,
  parameter int bank_count = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [port_count-1:0]            req,
  input  logic [port_count-1:0]            mem_write,
  input  logic [addr_width*port_count-1:0] address,
  input  logic [mem_width*port_count-1:0]  datain,
  output logic [port_count-1:0]            grant,
  output logic [mem_width*port_count-1:0]  dataout,
  output logic [port_count-1:0]            valid
);

  localparam int SEL_BITS = $clog2(bank_count);
  localparam int BANK_W   = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int PTR_W    = (port_count > 1) ? $clog2(port_count) : 1;
  localparam int ROWS     = mem_size / bank_count;
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [addr_width:0] LIMIT = (addr_width + 1)'(mem_size);

  logic [BANK_W-1:0]    bank_sel [port_count];
  logic [ROW_W-1:0]     row_sel  [port_count];
  logic [mem_width-1:0] wdata    [port_count];
  logic [port_count-1:0] in_range;

  logic [bank_count-1:0][PTR_W-1:0] rr_ptr;
  logic [bank_count-1:0][PTR_W-1:0] bank_win;
  logic [bank_count-1:0]            bank_busy;
  logic [PTR_W-1:0]                 scan;

  logic [mem_width-1:0] mem [bank_count][ROWS];

  logic [port_count-1:0][mem_width-1:0] rdata_p1;
  logic [port_count-1:0]                vld_p1;

  // Address decode: bank from the low bits, row from the rest. Rows of an
  // out-of-range address may alias a real row, so in_range gates every use.
  for (genvar j = 0; j < port_count; j++) begin : g_port
    logic [addr_width-1:0] addr;
    assign addr = address[j*addr_width +: addr_width];
    if (SEL_BITS > 0) begin : g_sel
      assign bank_sel[j] = addr[SEL_BITS-1:0];
    end else begin : g_nosel
      assign bank_sel[j] = '0;
    end
    assign row_sel[j]  = ROW_W'(addr >> SEL_BITS);
    assign in_range[j] = {1'b0, addr} < LIMIT;
    assign wdata[j]    = datain[j*mem_width +: mem_width];
  end

  // Stage p0: per-bank round-robin scan starting at that bank's pointer.
  always_comb begin
    bank_busy = '0;
    bank_win  = '0;
    grant     = '0;
    scan      = '0;
    if (!reset) begin
      for (int b = 0; b < bank_count; b++) begin
        for (int k = 0; k < port_count; k++) begin
          scan = PTR_W'((int'(rr_ptr[b]) + k) % port_count);
          if (!bank_busy[b] && req[scan] && int'(bank_sel[scan]) == b) begin
            bank_busy[b] = 1'b1;
            bank_win[b]  = scan;
            grant[scan]  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else begin
      for (int b = 0; b < bank_count; b++) begin
        if (bank_busy[b]) begin
          rr_ptr[b] <= PTR_W'((int'(bank_win[b]) + 1) % port_count);
        end
      end
    end
  end

  // Grants are exclusive per bank, so at most one port writes any bank.
  always_ff @(posedge clk) begin
    for (int j = 0; j < port_count; j++) begin
      if (grant[j] && mem_write[j] && in_range[j]) begin
        mem[bank_sel[j]][row_sel[j]] <= wdata[j];
      end
    end
  end

  // Stage p1: registered read data and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
      vld_p1   <= '0;
    end else begin
      vld_p1 <= grant & ~mem_write;
      for (int j = 0; j < port_count; j++) begin
        if (grant[j] && !mem_write[j]) begin
          rdata_p1[j] <= in_range[j] ? mem[bank_sel[j]][row_sel[j]] : '0;
        end
      end
    end
  end

  assign dataout = rdata_p1;
  // A read granted just before reset rises must not surface as valid.
  assign valid   = vld_p1 & ~{port_count{reset}};

endmodule

// File: tb/tb_multiport_banked_ram.sv
// Self-checking bench for multiport_banked_ram (2 ports, 4 banks, 12-bit).
// A flat-array reference model tracks memory, per-bank round-robin pointers
// and the expected registered outputs; a second instance with mem_size=2048
// exercises out-of-range accesses.
module tb_multiport_banked_ram;

  localparam int P  = 2;
  localparam int B  = 4;
  localparam int MS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, mem_write, grant, valid;
  logic [23:0] address, datain, dataout;

  logic [1:0]  req2, we2, grant2, valid2;
  logic [23:0] addr2, din2, dout2;

  always #5 clk = ~clk;

  multiport_banked_ram dut (
    .clk(clk), .reset(reset), .req(req), .mem_write(mem_write),
    .address(address), .datain(datain), .grant(grant),
    .dataout(dataout), .valid(valid)
  );

  multiport_banked_ram #(.mem_size(2048)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .mem_write(we2),
    .address(addr2), .datain(din2), .grant(grant2),
    .dataout(dout2), .valid(valid2)
  );

  int checks = 0;
  int errors = 0;

  // stimulus for the main instance
  bit          rst_v;
  bit   [1:0]  req_v, we_v;
  logic [11:0] addr_v [P];
  logic [11:0] din_v  [P];

  // reference model
  logic [11:0] mmem   [MS];
  bit          mknown [MS];
  int          mptr   [B];
  logic [1:0]  exp_g, exp_v;
  logic [11:0] exp_d  [P];
  bit          exp_dk [P];

  // outputs captured in the last cycle
  logic [1:0]  last_grant, last_valid;
  logic [23:0] last_dout;

  bit pend [P];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input int a, input int d);
    req_v[p]  = r;
    we_v[p]   = w;
    addr_v[p] = 12'(a);
    din_v[p]  = 12'(d);
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle();
    int  ptr_n [B];
    int  p;
    bit  taken;
    reset     = rst_v;
    req       = req_v;
    mem_write = we_v;
    for (int i = 0; i < P; i++) begin
      address[i*12 +: 12] = addr_v[i];
      datain[i*12 +: 12]  = din_v[i];
    end
    #1;
    exp_g = '0;
    for (int b = 0; b < B; b++) begin
      ptr_n[b] = mptr[b];
      taken = 1'b0;
      if (!rst_v) begin
        for (int k = 0; k < P; k++) begin
          p = (mptr[b] + k) % P;
          if (!taken && req_v[p] && (int'(addr_v[p]) % B) == b) begin
            exp_g[p] = 1'b1;
            ptr_n[b] = (p + 1) % P;
            taken = 1'b1;
          end
        end
      end
    end
    last_grant = grant;
    last_valid = valid;
    last_dout  = dataout;
    check("grant", grant, exp_g);
    check("valid", valid, rst_v ? 2'b00 : exp_v);
    for (int i = 0; i < P; i++)
      if (exp_dk[i]) check($sformatf("dataout%0d", i), dataout[i*12 +: 12], exp_d[i]);
    @(posedge clk);
    if (rst_v) begin
      for (int b = 0; b < B; b++) mptr[b] = 0;
      exp_v = '0;
      for (int i = 0; i < P; i++) begin
        exp_d[i]  = '0;
        exp_dk[i] = 1'b1;
      end
    end else begin
      for (int b = 0; b < B; b++) mptr[b] = ptr_n[b];
      exp_v = '0;
      for (int i = 0; i < P; i++) begin
        if (exp_g[i]) begin
          if (we_v[i]) begin
            if (int'(addr_v[i]) < MS) begin
              mmem[addr_v[i]]   = din_v[i];
              mknown[addr_v[i]] = 1'b1;
            end
          end else begin
            exp_v[i] = 1'b1;
            if (int'(addr_v[i]) < MS) begin
              exp_d[i]  = mmem[addr_v[i]];
              exp_dk[i] = mknown[addr_v[i]];
            end else begin
              exp_d[i]  = '0;
              exp_dk[i] = 1'b1;
            end
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // Drive port 0 of the mem_size=2048 instance, check its grant, run a cycle.
  task automatic step2(input bit r, input bit w, input int a, input int d, input logic [1:0] eg);
    req2 = {1'b0, r};
    we2  = {1'b0, w};
    addr2 = {12'h000, 12'(a)};
    din2  = {12'h000, 12'(d)};
    #1;
    check("grant2", grant2, eg);
    cycle();
  endtask

  initial begin
    rst_v = 1'b1; req_v = '0; we_v = '0;
    for (int i = 0; i < P; i++) begin
      addr_v[i] = '0; din_v[i] = '0; exp_d[i] = '0; exp_dk[i] = 1'b0; pend[i] = 1'b0;
    end
    for (int i = 0; i < MS; i++) mknown[i] = 1'b0;
    for (int b = 0; b < B; b++) mptr[b] = 0;
    exp_v = '0;
    req2 = '0; we2 = '0; addr2 = '0; din2 = '0;
    reset = 1'b1; req = '0; mem_write = '0; address = '0; datain = '0;
    @(negedge clk);

    // reset held two cycles
    cycle();
    cycle();
    rst_v = 1'b0;
    cycle();
    check("rst_valid", last_valid, 2'b00);
    check("rst_dout", last_dout, 24'h0);
    check("rst_grant", last_grant, 2'b00);

    // bank-0 conflict straight after reset; pointers start at 0
    set_port(0, 1, 0, 'h004, 0); set_port(1, 1, 0, 'h008, 0);
    cycle(); check("conf_n", last_grant, 2'b01);
    set_port(0, 0, 0, 0, 0);
    cycle(); check("conf_n1", last_grant, 2'b10); check("conf_v0", last_valid, 2'b01);
    set_port(0, 1, 0, 'h004, 0);
    cycle(); check("conf_n2", last_grant, 2'b01); check("conf_v1", last_valid, 2'b10);
    set_port(0, 0, 0, 0, 0);
    cycle(); check("conf_n3", last_grant, 2'b10); check("conf_v2", last_valid, 2'b01);
    set_port(1, 0, 0, 0, 0);
    cycle(); check("conf_v3", last_valid, 2'b10);

    // write then immediate read-back on port 0
    set_port(0, 1, 1, 'h010, 'h0A5);
    cycle(); check("wr_grant", last_grant, 2'b01);
    set_port(0, 1, 0, 'h010, 0);
    cycle(); check("rd_grant", last_grant, 2'b01); check("wr_novalid", last_valid, 2'b00);
    set_port(0, 0, 0, 0, 0);
    cycle(); check("rd_valid", last_valid, 2'b01); check("rd_data", last_dout[11:0], 12'h0A5);
    cycle(); check("rd_pulse", last_valid, 2'b00); check("rd_hold", last_dout[11:0], 12'h0A5);

    // parallel writes to different banks
    set_port(0, 1, 1, 'h001, 'h3C3); set_port(1, 1, 1, 'h002, 'h5A5);
    cycle(); check("par_wr", last_grant, 2'b11);
    set_port(0, 1, 0, 'h001, 0); set_port(1, 1, 0, 'h002, 0);
    cycle(); check("par_rd", last_grant, 2'b11);
    set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
    cycle(); check("par_d0", last_dout[11:0], 12'h3C3); check("par_d1", last_dout[23:12], 12'h5A5);
    check("par_v", last_valid, 2'b11);

    // out-of-range handling on the mem_size=2048 instance (0x900 aliases row of 0x100)
    step2(1, 1, 'h100, 'h123, 2'b01);
    step2(1, 1, 'h900, 'hFFF, 2'b01);
    check("oor_wr_v", valid2, 2'b00);
    step2(1, 0, 'h900, 0, 2'b01);
    check("oor_rd_v", valid2, 2'b01); check("oor_rd_d", dout2[11:0], 12'h000);
    step2(1, 0, 'h100, 0, 2'b01);
    check("alias_v", valid2, 2'b01); check("alias_d", dout2[11:0], 12'h123);
    step2(0, 0, 0, 0, 2'b00);
    check("alias_pulse", valid2, 2'b00); check("alias_hold", dout2[11:0], 12'h123);

    // initialise words 0..31 so random reads have known data
    for (int i = 0; i < 16; i++) begin
      set_port(0, 1, 1, 2*i, $urandom_range(0, 4095));
      set_port(1, 1, 1, 2*i + 1, $urandom_range(0, 4095));
      cycle();
    end

    // random traffic; a losing port holds its request until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < P; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            set_port(i, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 4095));
            pend[i] = 1'b1;
          end else begin
            set_port(i, 0, 0, 0, 0);
          end
        end
      end
      cycle();
      for (int i = 0; i < P; i++) if (exp_g[i]) pend[i] = 1'b0;
    end
    set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
    cycle();

    // reset right after a granted read suppresses valid; memory survives
    set_port(0, 1, 1, 'h020, 'h7E7);
    cycle();
    set_port(0, 1, 0, 'h020, 0);
    cycle(); check("pre_rst_grant", last_grant, 2'b01);
    set_port(0, 0, 0, 0, 0);
    rst_v = 1'b1;
    cycle(); check("rst_sup_v", last_valid, 2'b00);
    rst_v = 1'b0;
    cycle(); check("post_rst_v", last_valid, 2'b00); check("post_rst_d", last_dout, 24'h0);
    set_port(0, 1, 0, 'h020, 0); set_port(1, 1, 0, 'h005, 0);
    cycle(); check("post_rst_g", last_grant, 2'b11);
    set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
    cycle(); check("keep_d0", last_dout[11:0], 12'h7E7); check("keep_d1", last_dout[23:12], mmem[5]);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
